// File: rtl/joy_db15_scanner.sv
// Serial DB15 joystick adapter scanner: latches the external shift-register chain,
// clocks out 32 active-low bits and publishes two active-high 16-bit button words.
// Optional build macro JOY_DB15_DEBOUNCE_EN publishes a frame only when it repeats.
module joy_db15_scanner #(
    parameter int CLK_DIV     = 24,
    parameter int FRAME_TICKS = 256,
    parameter int NBITS       = 32
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] JOY1,
    output logic [15:0] JOY2,
    output logic        VALID
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT_L = 3'd2,
        SHIFT_H = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [15:0] DIV_MAX  = 16'(CLK_DIV - 1);
    localparam logic [15:0] IDLE_MAX = 16'(FRAME_TICKS - 1);
    localparam logic [4:0]  IDX_MAX  = 5'(NBITS - 1);

    state_t      state, state_n;
    logic [15:0] div_cnt;
    logic [15:0] idle_cnt, idle_n;
    logic [4:0]  idx, idx_n;
    logic [31:0] shift, shift_n;
    logic        clk_n, load_n, valid_n;
    logic [15:0] joy1_n, joy2_n;
    logic        tick;
`ifdef JOY_DB15_DEBOUNCE_EN
    logic [31:0] last_frame, last_n;
`endif

    assign tick = ENABLE && (div_cnt == DIV_MAX);

    // Scan-tick divider, parked at zero while scanning is not permitted
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            div_cnt <= 16'd0;
        end else if (!ENABLE || (div_cnt == DIV_MAX)) begin
            div_cnt <= 16'd0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Next-state and next-output logic for the scan sequencer
    always_comb begin
        state_n  = state;
        idle_n   = idle_cnt;
        idx_n    = idx;
        shift_n  = shift;
        clk_n    = JOY_CLK;
        load_n   = JOY_LOAD;
        joy1_n   = JOY1;
        joy2_n   = JOY2;
        valid_n  = 1'b0;
`ifdef JOY_DB15_DEBOUNCE_EN
        last_n   = last_frame;
`endif
        if (!ENABLE) begin
            state_n = IDLE;
            idle_n  = 16'd0;
            idx_n   = 5'd0;
            shift_n = 32'd0;
            clk_n   = 1'b0;
            load_n  = 1'b1;
            joy1_n  = 16'd0;
            joy2_n  = 16'd0;
`ifdef JOY_DB15_DEBOUNCE_EN
            last_n  = 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (tick && (idle_cnt == IDLE_MAX)) begin
                        idle_n  = 16'd0;
                        load_n  = 1'b0;
                        state_n = LOAD;
                    end else if (tick) begin
                        idle_n = idle_cnt + 16'd1;
                    end else begin
                        idle_n = idle_cnt;
                    end
                end
                LOAD: begin
                    if (tick) begin
                        load_n  = 1'b1;
                        idx_n   = 5'd0;
                        state_n = SHIFT_L;
                    end else begin
                        state_n = LOAD;
                    end
                end
                // Sample one tick after the preceding edge so the adapter has settled
                SHIFT_L: begin
                    if (tick) begin
                        shift_n[idx] = ~JOY_DATA;
                        clk_n        = 1'b1;
                        state_n      = SHIFT_H;
                    end else begin
                        state_n = SHIFT_L;
                    end
                end
                SHIFT_H: begin
                    if (tick && (idx == IDX_MAX)) begin
                        clk_n   = 1'b0;
                        state_n = DONE;
                    end else if (tick) begin
                        clk_n   = 1'b0;
                        idx_n   = idx + 5'd1;
                        state_n = SHIFT_L;
                    end else begin
                        state_n = SHIFT_H;
                    end
                end
                DONE: begin
                    state_n = IDLE;
`ifdef JOY_DB15_DEBOUNCE_EN
                    if (shift == last_frame) begin
                        joy1_n  = shift[15:0];
                        joy2_n  = shift[31:16];
                        valid_n = 1'b1;
                    end else begin
                        valid_n = 1'b0;
                    end
                    last_n = shift;
`else
                    joy1_n  = shift[15:0];
                    joy2_n  = shift[31:16];
                    valid_n = 1'b1;
`endif
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            idle_cnt <= 16'd0;
            idx      <= 5'd0;
            shift    <= 32'd0;
            JOY_CLK  <= 1'b0;
            JOY_LOAD <= 1'b1;
            JOY1     <= 16'd0;
            JOY2     <= 16'd0;
            VALID    <= 1'b0;
`ifdef JOY_DB15_DEBOUNCE_EN
            last_frame <= 32'd0;
`endif
        end else begin
            state    <= state_n;
            idle_cnt <= idle_n;
            idx      <= idx_n;
            shift    <= shift_n;
            JOY_CLK  <= clk_n;
            JOY_LOAD <= load_n;
            JOY1     <= joy1_n;
            JOY2     <= joy2_n;
            VALID    <= valid_n;
`ifdef JOY_DB15_DEBOUNCE_EN
            last_frame <= last_n;
`endif
        end
    end

endmodule

// File: tb/tb_joy_db15_scanner.sv
// Directed bench for joy_db15_scanner: two instances (4/8 and 2/1 timing) each
// driven by a behavioural model of the adapter's parallel-in/serial-out chain.
module tb_joy_db15_scanner;

`ifdef JOY_DB15_DEBOUNCE_EN
    localparam int REP       = 2;
    localparam bit DEB       = 1'b1;
    localparam int FIRST_VLD = 585;
`else
    localparam int REP       = 1;
    localparam bit DEB       = 1'b0;
    localparam int FIRST_VLD = 293;
`endif

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic        rst  = 1'b1;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        data_a, data_b;
    logic        jclk_a, jload_a, valid_a, jclk_b, jload_b, valid_b;
    logic [15:0] joy1_a, joy2_a, joy1_b, joy2_b;
    logic [31:0] pat_a = 32'd0;
    logic [31:0] pat_b = 32'd0;
    logic [31:0] sr_a  = 32'd0;
    logic [31:0] sr_b  = 32'd0;
    int          checks = 0;
    int          errors = 0;

    joy_db15_scanner #(.CLK_DIV(4), .FRAME_TICKS(8), .NBITS(32)) dut_a (
        .MCLK(mclk), .RESET(rst), .ENABLE(en_a), .JOY_DATA(data_a),
        .JOY_CLK(jclk_a), .JOY_LOAD(jload_a), .JOY1(joy1_a), .JOY2(joy2_a), .VALID(valid_a)
    );

    joy_db15_scanner #(.CLK_DIV(2), .FRAME_TICKS(1), .NBITS(32)) dut_b (
        .MCLK(mclk), .RESET(rst), .ENABLE(en_b), .JOY_DATA(data_b),
        .JOY_CLK(jclk_b), .JOY_LOAD(jload_b), .JOY1(joy1_b), .JOY2(joy2_b), .VALID(valid_b)
    );

    // Adapter: parallel load on latch low, shift toward bit 0 on each shift-clock rise
    assign data_a = ~sr_a[0];
    assign data_b = ~sr_b[0];
    always @(negedge jload_a or posedge jclk_a) begin
        if (!jload_a) sr_a = pat_a;
        else          sr_a = sr_a >> 1;
    end
    always @(negedge jload_b or posedge jclk_b) begin
        if (!jload_b) sr_b = pat_b;
        else          sr_b = sr_b >> 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs until the next falling latch, reporting whether VALID fired and its word
    task automatic frame_window(input bit sel, output bit seen, output logic [31:0] word);
        logic prev, cur;
        int   n;
        seen = 1'b0;
        word = 32'd0;
        prev = sel ? jload_b : jload_a;
        n    = 0;
        while (n < 1000) begin
            @(negedge mclk);
            n++;
            cur = sel ? jload_b : jload_a;
            if (sel ? valid_b : valid_a) begin
                seen = 1'b1;
                word = sel ? {joy2_b, joy1_b} : {joy2_a, joy1_a};
            end
            if (prev && !cur) break;
            prev = cur;
        end
        check("window_bound", 32'(n < 1000), 32'd1);
    endtask

    initial begin
        int          n, run, pulses, bad, changes, vcount;
        logic        prev;
        bit          seen;
        logic [31:0] word;
        logic [31:0] pats [3];
        pats[0] = 32'h0000_0001;
        pats[1] = 32'h0002_0000;
        pats[2] = 32'h8000_0000;

        repeat (3) @(negedge mclk);
        check("rst_jclk",  32'(jclk_a),  32'd0);
        check("rst_jload", 32'(jload_a), 32'd1);
        check("rst_joy1",  32'(joy1_a),  32'd0);
        check("rst_joy2",  32'(joy2_a),  32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        rst = 1'b0;
        @(negedge mclk);

        // Timing of latch, shift clocks and first frame
        pat_a = {16'h8000, 16'h0011};
        en_a  = 1'b1;
        n = 0;
        while (jload_a && n < 100) begin @(negedge mclk); n++; end
        check("latch_delay", n, 32'd32);
        n = 0;
        while (!jload_a && n < 100) begin @(negedge mclk); n++; end
        check("latch_width", n, 32'd4);
        run = 1; prev = 1'b0; pulses = 0; bad = 0; n = 0;
        while (!valid_a && n < 1000) begin
            @(negedge mclk);
            n++;
            if (!jload_a) begin
                run = 0; pulses = 0; prev = 1'b0;
            end else if (jclk_a == prev) begin
                run++;
            end else begin
                if (run != 4) bad++;
                if (jclk_a) pulses++;
                run  = 1;
                prev = jclk_a;
            end
        end
        check("clk_pulses", pulses, 32'd32);
        check("clk_widths", bad, 32'd0);
        check("f1_joy1", 32'(joy1_a), 32'h0011);
        check("f1_joy2", 32'(joy2_a), 32'h8000);
        @(negedge mclk);
        check("valid_width", 32'(valid_a), 32'd0);
        n = 0; changes = 0;
        while (!valid_a && n < 2000) begin
            if (joy1_a != 16'h0011 || joy2_a != 16'h8000) changes++;
            @(negedge mclk);
            n++;
        end
        check("hold_stable", changes, 32'd0);
        check("f2_joy1", 32'(joy1_a), 32'h0011);
        check("f2_joy2", 32'(joy2_a), 32'h8000);

        // Disable during bit 10 of the following frame
        pulses = 0; n = 0; prev = jclk_a;
        while (pulses < 11 && n < 1000) begin
            @(negedge mclk);
            n++;
            if (jclk_a && !prev) pulses++;
            prev = jclk_a;
        end
        check("mid_jclk_high", 32'(jclk_a), 32'd1);
        en_a = 1'b0;
        @(negedge mclk);
        check("dis_jclk",  32'(jclk_a),  32'd0);
        check("dis_jload", 32'(jload_a), 32'd1);
        check("dis_joy1",  32'(joy1_a),  32'd0);
        check("dis_joy2",  32'(joy2_a),  32'd0);
        check("dis_valid", 32'(valid_a), 32'd0);
        vcount = 0;
        repeat (50) begin @(negedge mclk); if (valid_a) vcount++; end
        check("dis_no_valid", vcount, 32'd0);
        pat_a = {16'h1234, 16'hA5C3};
        en_a  = 1'b1;
        n = 0;
        while (!valid_a && n < 2000) begin @(negedge mclk); n++; end
        check("re_joy1", 32'(joy1_a), 32'hA5C3);
        check("re_joy2", 32'(joy2_a), 32'h1234);

        // Asynchronous reset while the shift clock is high
        n = 0;
        while (!jclk_a && n < 1000) begin @(negedge mclk); n++; end
        #2 rst = 1'b1;
        #1;
        check("ar_jclk",  32'(jclk_a),  32'd0);
        check("ar_jload", 32'(jload_a), 32'd1);
        check("ar_joy1",  32'(joy1_a),  32'd0);
        check("ar_joy2",  32'(joy2_a),  32'd0);
        check("ar_valid", 32'(valid_a), 32'd0);
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b0;
        n = 0;
        while (!valid_a && n < 2000) begin @(negedge mclk); n++; end
        check("ar_first_valid", n, FIRST_VLD);
        check("ar_joy1_new", 32'(joy1_a), 32'hA5C3);

        // Frames A, B, B
        frame_window(1'b0, seen, word);
        pat_a = 32'hF0F0_0F0F;
        frame_window(1'b0, seen, word);
        pat_a = 32'h2468_1357;
        frame_window(1'b0, seen, word);
        check("fa_valid", 32'(seen), 32'(!DEB));
        check("fa_word",  word, DEB ? 32'd0 : 32'hF0F0_0F0F);
        frame_window(1'b0, seen, word);
        check("fb1_valid", 32'(seen), 32'(!DEB));
        check("fb1_word",  word, DEB ? 32'd0 : 32'h2468_1357);
        frame_window(1'b0, seen, word);
        check("fb2_valid", 32'(seen), 32'd1);
        check("fb2_word",  word, 32'h2468_1357);

        // Minimum timing, walking-one frames
        pat_b = pats[0];
        en_b  = 1'b1;
        n = 0;
        while (jload_b && n < 100) begin @(negedge mclk); n++; end
        check("b_latch_delay", n, 32'd2);
        n = 0;
        while (!jload_b && n < 100) begin @(negedge mclk); n++; end
        check("b_latch_width", n, 32'd2);
        for (int j = 0; j < 3 * REP; j++) begin
            pat_b = pats[((j + 1) / REP > 2) ? 2 : (j + 1) / REP];
            frame_window(1'b1, seen, word);
            if (j % REP == REP - 1) begin
                check("walk_valid", 32'(seen), 32'd1);
                check("walk_word",  word, pats[j / REP]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
